gcd_modulo_master: RTL and testbench

Initiator for the existing modulo unit's start/valid handshake. It takes two operands, computes their greatest common divisor with Euclid's algorithm, and issues one modulo request per step. It drives Zahl1/Zahl2/start into the modulo core and consumes its valid/ergebnis, so it sits directly upstream of modulo_top.

---
 rtl/gcd_modulo_master.sv | 148 ++++++++++++++
 tb/tb_gcd_modulo_master.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_modulo_master.sv
// Euclid GCD sequencer that drives the modulo core through its start/valid handshake.
// Optional macro GCD_MODULO_TIMEOUT_EN adds a per-request watchdog of TIMEOUT_CYCLES.
module gcd_modulo_master #(
  parameter int W              = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [W-1:0] gcd_o,
  output logic [5:0]   iter_o,
  output logic         mod_start_o,
  output logic [W-1:0] mod_zahl1_o,
  output logic [W-1:0] mod_zahl2_o,
  input  logic         mod_valid_i,
  input  logic [W-1:0] mod_ergebnis_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t         state, next_state;
  logic [W-1:0]   x, y, gcd_q, zahl1_q, zahl2_q;
  logic [5:0]     iter_q;
  logic           valid_q, err_q;
  logic           accept, bad_rem, timeout_hit;

  // Only a fresh rising edge of valid counts, so a level left over from an earlier request is ignored.
  assign accept  = (state == S_WAIT) && mod_valid_i && !valid_q;
  assign bad_rem = (mod_ergebnis_i >= y);

`ifdef GCD_MODULO_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst_i || state != S_WAIT) begin
      wait_cnt <= '0;
    end else if (!accept) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == S_WAIT) && !accept &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          next_state = (b_i == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: next_state = S_WAIT;
      S_WAIT: begin
        if (accept) begin
          next_state = (bad_rem || mod_ergebnis_i == '0) ? S_DONE : S_ISSUE;
        end else if (timeout_hit) begin
          next_state = S_DONE;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      x       <= '0;
      y       <= '0;
      gcd_q   <= '0;
      zahl1_q <= '0;
      zahl2_q <= '0;
      iter_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= mod_valid_i;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            x      <= a_i;
            y      <= b_i;
            iter_q <= '0;
            err_q  <= 1'b0;
            if (b_i == '0) begin
              gcd_q <= a_i;
            end
          end
        end
        S_ISSUE: begin
          zahl1_q <= x;
          zahl2_q <= y;
        end
        S_WAIT: begin
          if (accept) begin
            if (bad_rem) begin
              err_q <= 1'b1;
              gcd_q <= '0;
            end else begin
              x      <= y;
              y      <= mod_ergebnis_i;
              iter_q <= (iter_q == 6'd63) ? iter_q : iter_q + 6'd1;
              if (mod_ergebnis_i == '0) begin
                gcd_q <= y;
              end
            end
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            gcd_q <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Operands are shown live during ISSUE and then held from the captured copy.
  always_comb begin
    busy_o      = (state != S_IDLE);
    done_o      = (state == S_DONE);
    err_o       = (state == S_DONE) && err_q;
    mod_start_o = (state == S_ISSUE);
    mod_zahl1_o = (state == S_ISSUE) ? x : zahl1_q;
    mod_zahl2_o = (state == S_ISSUE) ? y : zahl2_q;
    gcd_o       = gcd_q;
    iter_o      = iter_q;
  end

endmodule

// File: tb/tb_gcd_modulo_master.sv
// Directed bench for gcd_modulo_master with a behavioural modulo-core responder.
// Define GCD_MODULO_TIMEOUT_EN to also exercise the watchdog (built with TIMEOUT_CYCLES=16).
module tb_gcd_modulo_master;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] a_i = '0, b_i = '0;
  logic        busy_o, done_o, err_o, mod_start_o;
  logic [15:0] gcd_o, mod_zahl1_o, mod_zahl2_o;
  logic [5:0]  iter_o;
  logic        mod_valid_i;
  logic [15:0] mod_ergebnis_i;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  gcd_modulo_master #(.W(16), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_i(rst_i), .start_i(start_i), .a_i(a_i), .b_i(b_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .gcd_o(gcd_o), .iter_o(iter_o),
    .mod_start_o(mod_start_o), .mod_zahl1_o(mod_zahl1_o), .mod_zahl2_o(mod_zahl2_o),
    .mod_valid_i(mod_valid_i), .mod_ergebnis_i(mod_ergebnis_i)
  );

  // Responder: valid rises 3 cycles after a start pulse and stays high for 2 cycles.
  typedef enum {M_NORMAL, M_ERR, M_NEVER} mode_t;
  mode_t       mode = M_NORMAL;
  logic        resp_valid = 1'b0;
  logic [15:0] resp_erg = '0;
  logic [15:0] pend = '0;
  int          dly = 0, hold = 0, n_starts = 0, n_orphan_err = 0;
  logic [15:0] q1[$], q2[$];

  logic        force_en = 1'b0, force_valid = 1'b0;
  logic [15:0] force_erg = '0;

  assign mod_valid_i    = force_en ? force_valid : resp_valid;
  assign mod_ergebnis_i = force_en ? force_erg : resp_erg;

  always @(negedge clk) begin
    if (hold > 0) begin
      hold--;
      if (hold == 0) resp_valid = 1'b0;
    end
    if (dly > 0) begin
      dly--;
      if (dly == 0 && mode != M_NEVER) begin
        resp_valid = 1'b1;
        resp_erg   = pend;
        hold       = 2;
      end
    end
    if (mod_start_o === 1'b1) begin
      q1.push_back(mod_zahl1_o);
      q2.push_back(mod_zahl2_o);
      n_starts++;
      dly  = 3;
      pend = (mode == M_ERR) ? 16'd20 : (mod_zahl1_o % mod_zahl2_o);
    end
    if (err_o === 1'b1 && done_o !== 1'b1) n_orphan_err++;
  end

  task automatic do_start(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    a_i = a;
    b_i = b;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit found, output int cyc,
                           output logic [15:0] g, output logic [5:0] it, output logic e);
    found = 1'b0; cyc = 0; g = '0; it = '0; e = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done_o === 1'b1) begin
        found = 1'b1; cyc = i; g = gcd_o; it = iter_o; e = err_o;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [57:0] outs;
    repeat (2) @(negedge clk);
    outs = {busy_o, done_o, err_o, mod_start_o, gcd_o, iter_o, mod_zahl1_o, mod_zahl2_o};
    checks++;
    if (outs !== 58'd0) $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
    else passes++;
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) $display("[TB] FAIL idle_after_reset: busy=%b done=%b expected 0/0", busy_o, done_o);
    else passes++;
  endtask

  task automatic test_long_euclid;
    logic [15:0] exp1 [8] = '{24255, 9540, 5175, 4365, 810, 315, 180, 135};
    logic [15:0] exp2 [8] = '{9540, 5175, 4365, 810, 315, 180, 135, 45};
    int base, cyc; bit found; logic [15:0] g; logic [5:0] it; logic e;
    base = q1.size();
    do_start(16'd24255, 16'd9540);
    wait_done(200, found, cyc, g, it, e);
    checks++;
    if (!found || g !== 16'd45 || it !== 6'd8 || e !== 1'b0)
      $display("[TB] FAIL long_result: found=%0d gcd=%0d iter=%0d err=%b expected 1/45/8/0", found, g, it, e);
    else passes++;
    checks++;
    if (cyc !== 32) $display("[TB] FAIL long_latency: got %0d expected 32", cyc);
    else passes++;
    checks++;
    if (q1.size() - base !== 8) $display("[TB] FAIL long_requests: got %0d expected 8", q1.size() - base);
    else passes++;
    for (int i = 0; i < 8 && base + i < q1.size(); i++) begin
      checks++;
      if (q1[base+i] !== exp1[i] || q2[base+i] !== exp2[i])
        $display("[TB] FAIL long_pair%0d: got %0d,%0d expected %0d,%0d", i, q1[base+i], q2[base+i], exp1[i], exp2[i]);
      else passes++;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_busy_ignore;
    int s0, cyc; bit found; logic [15:0] g; logic [5:0] it; logic e;
    s0 = n_starts;
    do_start(16'd48, 16'd18);
    repeat (3) @(negedge clk);
    a_i = 16'd100; b_i = 16'd7; start_i = 1'b1;
    checks++;
    if (busy_o !== 1'b1) $display("[TB] FAIL busy_mid_job: got %b expected 1", busy_o);
    else passes++;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(200, found, cyc, g, it, e);
    checks++;
    if (!found || g !== 16'd6 || it !== 6'd3 || e !== 1'b0)
      $display("[TB] FAIL busy_result: found=%0d gcd=%0d iter=%0d err=%b expected 1/6/3/0", found, g, it, e);
    else passes++;
    repeat (8) @(negedge clk);
    checks++;
    if (n_starts - s0 !== 3) $display("[TB] FAIL busy_requests: got %0d expected 3", n_starts - s0);
    else passes++;
    checks++;
    if (mod_zahl1_o !== 16'd12 || mod_zahl2_o !== 16'd6)
      $display("[TB] FAIL operands_hold_idle: got %0d,%0d expected 12,6", mod_zahl1_o, mod_zahl2_o);
    else passes++;
  endtask

  task automatic test_zero_operands;
    int s0, cyc; bit found; logic [15:0] g; logic [5:0] it; logic e;
    s0 = n_starts;
    do_start(16'd77, 16'd0);
    wait_done(50, found, cyc, g, it, e);
    checks++;
    if (!found || cyc !== 0 || g !== 16'd77 || it !== 6'd0 || e !== 1'b0)
      $display("[TB] FAIL b_zero: found=%0d cyc=%0d gcd=%0d iter=%0d err=%b expected 1/0/77/0/0", found, cyc, g, it, e);
    else passes++;
    repeat (6) @(negedge clk);
    checks++;
    if (n_starts !== s0) $display("[TB] FAIL b_zero_requests: got %0d expected 0", n_starts - s0);
    else passes++;
    do_start(16'd0, 16'd5);
    wait_done(50, found, cyc, g, it, e);
    checks++;
    if (!found || g !== 16'd5 || it !== 6'd1 || e !== 1'b0)
      $display("[TB] FAIL a_zero: found=%0d gcd=%0d iter=%0d err=%b expected 1/5/1/0", found, g, it, e);
    else passes++;
    repeat (8) @(negedge clk);
    s0 = n_starts;
    do_start(16'd0, 16'd0);
    wait_done(50, found, cyc, g, it, e);
    checks++;
    if (!found || g !== 16'd0 || it !== 6'd0 || e !== 1'b0)
      $display("[TB] FAIL both_zero: found=%0d gcd=%0d iter=%0d err=%b expected 1/0/0/0", found, g, it, e);
    else passes++;
    repeat (6) @(negedge clk);
    checks++;
    if (n_starts !== s0) $display("[TB] FAIL both_zero_requests: got %0d expected 0", n_starts - s0);
    else passes++;
  endtask

  task automatic test_bad_remainder;
    int s0, cyc; bit found; logic [15:0] g; logic [5:0] it; logic e;
    s0 = n_starts;
    mode = M_ERR;
    do_start(16'd48, 16'd18);
    wait_done(100, found, cyc, g, it, e);
    checks++;
    if (!found || e !== 1'b1 || g !== 16'd0 || it !== 6'd0)
      $display("[TB] FAIL bad_rem: found=%0d err=%b gcd=%0d iter=%0d expected 1/1/0/0", found, e, g, it);
    else passes++;
    mode = M_NORMAL;
    repeat (8) @(negedge clk);
    checks++;
    if (n_starts - s0 !== 1) $display("[TB] FAIL bad_rem_requests: got %0d expected 1", n_starts - s0);
    else passes++;
  endtask

  task automatic test_valid_held_high;
    int cyc; bit found; logic [15:0] g; logic [5:0] it; logic e;
    mode = M_NEVER;
    @(negedge clk);
    force_en = 1'b1; force_valid = 1'b1; force_erg = 16'd0;
    do_start(16'd48, 16'd18);
    repeat (6) @(negedge clk);
    checks++;
    if (busy_o !== 1'b1) $display("[TB] FAIL stale_valid_ignored: busy got %b expected 1", busy_o);
    else passes++;
    checks++;
    if (mod_zahl1_o !== 16'd48 || mod_zahl2_o !== 16'd18)
      $display("[TB] FAIL operands_hold_wait: got %0d,%0d expected 48,18", mod_zahl1_o, mod_zahl2_o);
    else passes++;
    force_valid = 1'b0;
    mode = M_NORMAL;
    @(negedge clk);
    force_valid = 1'b1; force_erg = 16'd12;
    @(negedge clk);
    force_en = 1'b0; force_valid = 1'b0;
    wait_done(200, found, cyc, g, it, e);
    checks++;
    if (!found || g !== 16'd6 || it !== 6'd3 || e !== 1'b0)
      $display("[TB] FAIL stale_valid_result: found=%0d gcd=%0d iter=%0d err=%b expected 1/6/3/0", found, g, it, e);
    else passes++;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid_job;
    logic [57:0] outs;
    int ndone, cyc; bit found; logic [15:0] g; logic [5:0] it; logic e;
    do_start(16'd24255, 16'd9540);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    outs = {busy_o, done_o, err_o, mod_start_o, gcd_o, iter_o, mod_zahl1_o, mod_zahl2_o};
    checks++;
    if (outs !== 58'd0) $display("[TB] FAIL reset_mid_job: got %h expected 0", outs);
    else passes++;
    rst_i = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_o === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0) $display("[TB] FAIL aborted_no_done: got %0d expected 0", ndone);
    else passes++;
    do_start(16'd48, 16'd18);
    wait_done(200, found, cyc, g, it, e);
    checks++;
    if (!found || g !== 16'd6 || it !== 6'd3 || e !== 1'b0)
      $display("[TB] FAIL after_reset_result: found=%0d gcd=%0d iter=%0d err=%b expected 1/6/3/0", found, g, it, e);
    else passes++;
    checks++;
    if (cyc !== 12) $display("[TB] FAIL after_reset_latency: got %0d expected 12", cyc);
    else passes++;
    repeat (8) @(negedge clk);
  endtask

`ifdef GCD_MODULO_TIMEOUT_EN
  task automatic test_timeout;
    int cyc; bit found; logic [15:0] g; logic [5:0] it; logic e;
    mode = M_NEVER;
    do_start(16'd48, 16'd18);
    wait_done(100, found, cyc, g, it, e);
    checks++;
    if (!found || cyc !== 17 || e !== 1'b1 || g !== 16'd0 || it !== 6'd0)
      $display("[TB] FAIL timeout: found=%0d cyc=%0d err=%b gcd=%0d iter=%0d expected 1/17/1/0/0", found, cyc, e, g, it);
    else passes++;
    mode = M_NORMAL;
    repeat (4) @(negedge clk);
  endtask
`endif

  initial begin
    $display("[TB] starting gcd_modulo_master bench");
    test_reset();
    test_long_euclid();
    test_busy_ignore();
    test_zero_operands();
    test_bad_remainder();
    test_valid_held_high();
    test_reset_mid_job();
`ifdef GCD_MODULO_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (n_orphan_err !== 0) $display("[TB] FAIL err_without_done: got %0d expected 0", n_orphan_err);
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
